// File: rtl/avmm_lvds_req_bridge.sv
// rtl/avmm_lvds_req_bridge.sv - Avalon-MM requester that frames commands onto a 32-bit request link
module avmm_lvds_req_bridge #(
    parameter int BURST_W = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [31:0]        avs_address_i,
    input  logic               avs_read_i,
    input  logic               avs_write_i,
    input  logic [31:0]        avs_writedata_i,
    input  logic [3:0]         avs_byteenable_i,
    input  logic [BURST_W-1:0] avs_burstcount_i,
    output logic               avs_waitrequest_o,
    output logic [31:0]        avs_readdata_o,
    output logic               avs_readdatavalid_o,
    output logic [1:0]         avs_response_o,
    output logic [31:0]        req_tx_data_o,
    output logic               req_tx_valid_o,
    input  logic [31:0]        resp_rx_data_i,
    input  logic               resp_rx_valid_i
);

    localparam int                 TMO_W     = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]   TMO_LIMIT = TMO_W'(TIMEOUT);
    localparam logic [BURST_W-1:0] ONE_BEAT  = BURST_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_ADDR,
        S_WDATA,
        S_RWAIT
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [31:0]        r_addr;
    logic [3:0]         r_be;
    logic [BURST_W-1:0] r_beats;
    logic               r_is_write;
    logic [31:0]        r_wdata;
    logic               r_beat_valid;
    logic [TMO_W-1:0]   r_tmo;
    logic [31:0]        r_rdata;
    logic               r_rdv;
    logic [1:0]         r_resp;

    logic [31:0]        w_h0;
    logic               w_wait;
    logic               w_tx_valid;
    logic [31:0]        w_tx_data;
    logic               w_accept;
    logic               w_enter_rwait;
    logic               w_in_wdata;
    logic               w_beat_send;
    logic               w_beat_take;
    logic               w_rd_word;
    logic               w_rd_fill;
    logic               w_last;
    logic               w_tmo_hit;

    assign w_last    = (r_beats == ONE_BEAT);
    assign w_tmo_hit = (r_tmo == TMO_LIMIT);

    // Header word: direction, byte enables and the normalised beat count
    always_comb begin
        w_h0                = '0;
        w_h0[BURST_W-1:0]   = r_beats;
        w_h0[27:24]         = r_be;
        w_h0[31]            = r_is_write;
    end

    // Next-state and per-state strobes; waitrequest is only released where a command or beat can be taken
    always_comb begin
        w_next        = r_state;
        w_wait        = 1'b1;
        w_tx_valid    = 1'b0;
        w_tx_data     = '0;
        w_accept      = 1'b0;
        w_enter_rwait = 1'b0;
        w_in_wdata    = 1'b0;
        w_beat_send   = 1'b0;
        w_beat_take   = 1'b0;
        w_rd_word     = 1'b0;
        w_rd_fill     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_wait   = 1'b0;
                w_accept = avs_read_i | avs_write_i;
                if (w_accept) begin
                    w_next = S_HDR;
                end
            end
            S_HDR: begin
                w_tx_valid = 1'b1;
                w_tx_data  = w_h0;
                w_next     = S_ADDR;
            end
            S_ADDR: begin
                w_tx_valid = 1'b1;
                w_tx_data  = r_addr;
                if (r_is_write) begin
                    w_next = S_WDATA;
                end else begin
                    w_enter_rwait = 1'b1;
                    w_next        = S_RWAIT;
                end
            end
            S_WDATA: begin
                w_in_wdata = 1'b1;
                if (r_beat_valid) begin
                    w_tx_valid  = 1'b1;
                    w_tx_data   = r_wdata;
                    w_beat_send = 1'b1;
                    // the beat on the link now is the last one: nothing more to take
                    w_wait      = w_last;
                    if (w_last) begin
                        w_next = S_IDLE;
                    end
                end else begin
                    w_wait = 1'b0;
                end
                w_beat_take = avs_write_i & ~w_wait;
            end
            S_RWAIT: begin
                // once the timeout fires, the rest of the burst is filled regardless of late words
                if (w_tmo_hit) begin
                    w_rd_fill = 1'b1;
                end else begin
                    w_rd_word = resp_rx_valid_i;
                end
                if ((w_rd_fill | w_rd_word) && w_last) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Command latch, beat counter, timeout counter and registered read return path
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_addr       <= '0;
            r_be         <= '0;
            r_beats      <= '0;
            r_is_write   <= 1'b0;
            r_wdata      <= '0;
            r_beat_valid <= 1'b0;
            r_tmo        <= '0;
            r_rdata      <= '0;
            r_rdv        <= 1'b0;
            r_resp       <= '0;
        end else begin
            r_rdv  <= 1'b0;
            r_resp <= 2'b00;
            if (w_accept) begin
                r_addr       <= avs_address_i;
                r_be         <= avs_byteenable_i;
                r_beats      <= (avs_burstcount_i == '0) ? ONE_BEAT : avs_burstcount_i;
                r_is_write   <= avs_write_i;
                r_wdata      <= avs_writedata_i;
                r_beat_valid <= avs_write_i;
            end
            if (w_enter_rwait) begin
                r_tmo <= '0;
            end
            if (w_in_wdata) begin
                r_beat_valid <= w_beat_take;
                if (w_beat_take) begin
                    r_wdata <= avs_writedata_i;
                end
            end
            if (w_beat_send) begin
                r_beats <= r_beats - ONE_BEAT;
            end
            if (w_rd_fill) begin
                r_rdata <= 32'hDEAD_BEEF;
                r_rdv   <= 1'b1;
                r_resp  <= 2'b10;
                r_beats <= r_beats - ONE_BEAT;
            end else if (w_rd_word) begin
                r_rdata <= resp_rx_data_i;
                r_rdv   <= 1'b1;
                r_beats <= r_beats - ONE_BEAT;
                r_tmo   <= '0;
            end else if (r_state == S_RWAIT) begin
                r_tmo   <= r_tmo + TMO_W'(1);
            end
        end
    end

    assign avs_waitrequest_o   = w_wait | ~rst_n_i;
    assign avs_readdata_o      = r_rdata;
    assign avs_readdatavalid_o = r_rdv;
    assign avs_response_o      = r_resp;
    assign req_tx_data_o       = w_tx_data;
    assign req_tx_valid_o      = w_tx_valid;

endmodule

// File: tb/tb_avmm_lvds_req_bridge.sv
// tb/tb_avmm_lvds_req_bridge.sv - scoreboard bench for avmm_lvds_req_bridge
module tb_avmm_lvds_req_bridge;

    localparam int BW  = 8;
    localparam int TMO = 1024;

    logic          clk;
    logic          rst_n;
    logic [31:0]   avs_address;
    logic          avs_read;
    logic          avs_write;
    logic [31:0]   avs_writedata;
    logic [3:0]    avs_byteenable;
    logic [BW-1:0] avs_burstcount;
    logic          avs_waitrequest;
    logic [31:0]   avs_readdata;
    logic          avs_readdatavalid;
    logic [1:0]    avs_response;
    logic [31:0]   req_tx_data;
    logic          req_tx_valid;
    logic [31:0]   resp_rx_data;
    logic          resp_rx_valid;

    avmm_lvds_req_bridge #(.BURST_W(BW), .TIMEOUT(TMO)) dut (
        .clk_i               (clk),
        .rst_n_i             (rst_n),
        .avs_address_i       (avs_address),
        .avs_read_i          (avs_read),
        .avs_write_i         (avs_write),
        .avs_writedata_i     (avs_writedata),
        .avs_byteenable_i    (avs_byteenable),
        .avs_burstcount_i    (avs_burstcount),
        .avs_waitrequest_o   (avs_waitrequest),
        .avs_readdata_o      (avs_readdata),
        .avs_readdatavalid_o (avs_readdatavalid),
        .avs_response_o      (avs_response),
        .req_tx_data_o       (req_tx_data),
        .req_tx_valid_o      (req_tx_valid),
        .resp_rx_data_i      (resp_rx_data),
        .resp_rx_valid_i     (resp_rx_valid)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        int          prev;   // -1 any, 0 previous cycle idle, 1 previous cycle valid
        int          cyc;    // -1 any, else exact cycle stamp
    } exp_t;

    exp_t        link_q[$];
    exp_t        rd_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic        prev_tx  = 1'b0;
    logic        prev_rdv = 1'b0;
    logic [31:0] wbuf[16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a link word or read data
    always @(negedge clk) begin
        exp_t e;
        if (req_tx_valid) begin
            n_cmp++;
            if (link_q.size() == 0) begin
                n_err++;
                $display("FAIL link_unexpected: got %h expected no word", req_tx_data);
            end else begin
                e = link_q.pop_front();
                if (req_tx_data !== e.data || (e.prev >= 0 && prev_tx !== e.prev[0])) begin
                    n_err++;
                    $display("FAIL link_word: got %h prev_valid %0b expected %h prev %0d",
                             req_tx_data, prev_tx, e.data, e.prev);
                end
            end
        end
        if (avs_readdatavalid) begin
            n_cmp++;
            if (rd_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected: got %h resp %b expected no data", avs_readdata, avs_response);
            end else begin
                e = rd_q.pop_front();
                if (avs_readdata !== e.data || avs_response !== e.resp ||
                    (e.prev >= 0 && prev_rdv !== e.prev[0]) || (e.cyc >= 0 && cyc != e.cyc)) begin
                    n_err++;
                    $display("FAIL rd_word: got %h resp %b cyc %0d expected %h resp %b cyc %0d prev %0d",
                             avs_readdata, avs_response, cyc, e.data, e.resp, e.cyc, e.prev);
                end
            end
        end
        prev_tx  = req_tx_valid;
        prev_rdv = avs_readdatavalid;
    end

    task automatic push_link(input logic [31:0] d, input int prev);
        exp_t e;
        e.data = d; e.resp = 2'b00; e.prev = prev; e.cyc = -1;
        link_q.push_back(e);
    endtask

    // Holds current request until waitrequest is low at a clock edge; returns 1 ns after that edge
    task automatic accept_beat();
        int n = 0;
        @(negedge clk);
        while (avs_waitrequest && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            chk("accept_timeout", 32'(n), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] be, input int bc,
                            input int gap_at, input logic also_read);
        int n;
        n = (bc == 0) ? 1 : bc;
        push_link({1'b1, 3'b000, be, 16'h0000, 8'(n)}, -1);
        push_link(addr, 1);
        for (int i = 0; i < n; i++) push_link(wbuf[i], (i == gap_at) ? 0 : 1);
        avs_address    = addr;
        avs_byteenable = be;
        avs_burstcount = 8'(bc);
        avs_writedata  = wbuf[0];
        avs_write      = 1'b1;
        avs_read       = also_read;
        accept_beat();
        avs_read = 1'b0;
        for (int i = 1; i < n; i++) begin
            if (i == gap_at) begin
                avs_write = 1'b0;
                @(posedge clk);
                #1;
            end
            avs_write     = 1'b1;
            avs_writedata = wbuf[i];
            accept_beat();
        end
        avs_write = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input int bc);
        push_link({1'b0, 3'b000, 4'hF, 16'h0000, 8'(bc)}, -1);
        push_link(addr, 1);
        avs_address    = addr;
        avs_byteenable = 4'hF;
        avs_burstcount = 8'(bc);
        avs_read       = 1'b1;
        accept_beat();
        avs_read = 1'b0;
    endtask

    // One response word on the link; read data must come back exactly one cycle later
    task automatic send_resp(input logic [31:0] d);
        exp_t e;
        e.data = d; e.resp = 2'b00; e.prev = -1; e.cyc = cyc + 1;
        rd_q.push_back(e);
        resp_rx_data  = d;
        resp_rx_valid = 1'b1;
        @(posedge clk);
        #1;
        resp_rx_valid = 1'b0;
        resp_rx_data  = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_waitrequest"}, 32'(avs_waitrequest), 32'd1);
        chk({tag, "_tx_valid"}, 32'(req_tx_valid), 32'd0);
        chk({tag, "_tx_data"}, req_tx_data, 32'd0);
        chk({tag, "_rdv"}, 32'(avs_readdatavalid), 32'd0);
        chk({tag, "_readdata"}, avs_readdata, 32'd0);
        chk({tag, "_response"}, 32'(avs_response), 32'd0);
    endtask

    initial begin
        int   gaps[8];
        logic [31:0] rdat[8];
        exp_t e;
        int   n;
        gaps = '{0, 1, 0, 2, 1, 0, 3, 0};
        rdat = '{32'h1000_0001, 32'h2000_0002, 32'h3000_0003, 32'h4000_0004,
                 32'h5000_0005, 32'h6000_0006, 32'h7000_0007, 32'h8000_0008};
        rst_n = 1'b0;
        avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
        avs_byteenable = '0; avs_burstcount = '0; resp_rx_data = '0; resp_rx_valid = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_waitrequest", 32'(avs_waitrequest), 32'd0);
        @(posedge clk);
        #1;

        // single write
        wbuf[0] = 32'hA5A5_1234;
        do_write(32'h0002_0010, 4'hF, 1, -1, 1'b0);

        // burstcount 0 as 1, read+write together as write, partial byte enables in header
        wbuf[0] = 32'h0BAD_F00D;
        do_write(32'h0000_0100, 4'h3, 0, -1, 1'b1);

        // single read, response after 5 cycles; waitrequest held meanwhile
        do_read(32'h0003_1000, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("read_waitrequest_held", 32'(avs_waitrequest), 32'd1);
        end
        @(posedge clk);
        #1;
        send_resp(32'h1122_3344);
        @(negedge clk);
        chk("read_done_idle", 32'(avs_waitrequest), 32'd0);
        @(posedge clk);
        #1;

        // write burst of 4 with master idle after beat 2
        wbuf[0] = 32'hC0DE_0000; wbuf[1] = 32'hC0DE_1111;
        wbuf[2] = 32'hC0DE_2222; wbuf[3] = 32'hC0DE_3333;
        do_write(32'h0020_0000, 4'hF, 4, 2, 1'b0);

        // read burst of 8 with gapped response words
        do_read(32'h0040_0000, 8);
        repeat (2) begin @(posedge clk); #1; end
        for (int i = 0; i < 8; i++) begin
            repeat (gaps[i]) begin @(posedge clk); #1; end
            send_resp(rdat[i]);
        end
        @(negedge clk);
        chk("burst_read_idle", 32'(avs_waitrequest), 32'd0);
        @(posedge clk);
        #1;

        // stray response word in IDLE is dropped
        resp_rx_data  = 32'hBAAD_BAAD;
        resp_rx_valid = 1'b1;
        @(posedge clk);
        #1;
        resp_rx_valid = 1'b0;
        resp_rx_data  = '0;
        @(negedge clk);
        chk("stray_word_dropped", 32'(avs_readdatavalid), 32'd0);
        @(posedge clk);
        #1;

        // read of 3 with no response: timeout fill
        for (int i = 0; i < 3; i++) begin
            e.data = 32'hDEAD_BEEF; e.resp = 2'b10; e.prev = (i == 0) ? -1 : 1; e.cyc = -1;
            rd_q.push_back(e);
        end
        do_read(32'h0050_0000, 3);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!avs_readdatavalid && n < TMO + 50);
        chk("timeout_latency_in_range", 32'((n >= TMO) && (n <= TMO + 8)), 32'd1);
        n = 0;
        while (rd_q.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("timeout_fill_drained", 32'(rd_q.size()), 32'd0);
        chk("timeout_idle", 32'(avs_waitrequest), 32'd0);
        @(posedge clk);
        #1;

        // next command after timeout behaves normally
        do_read(32'h0050_0040, 1);
        repeat (2) begin @(posedge clk); #1; end
        send_resp(32'hCAFE_F00D);
        @(negedge clk);
        chk("post_timeout_idle", 32'(avs_waitrequest), 32'd0);
        @(posedge clk);
        #1;

        // reset asserted during WDATA
        push_link(32'h8F00_0004, -1);
        push_link(32'h0060_0000, 1);
        push_link(32'h7777_0001, 1);
        avs_address    = 32'h0060_0000;
        avs_byteenable = 4'hF;
        avs_burstcount = 8'd4;
        avs_writedata  = 32'h7777_0001;
        avs_write      = 1'b1;
        accept_beat();
        avs_writedata  = 32'h7777_0002;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midframe_reset");
        avs_write = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_reset_idle", 32'(avs_waitrequest), 32'd0);
        @(posedge clk);
        #1;
        wbuf[0] = 32'h5555_AAAA;
        do_write(32'h0000_0044, 4'hF, 1, -1, 1'b0);

        repeat (6) @(negedge clk);
        chk("link_queue_empty", 32'(link_q.size()), 32'd0);
        chk("read_queue_empty", 32'(rd_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
